// File: rtl/sram_array_1r1w_init_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_array_1r1w_init_if
// Description : Access bundle for the 1R1W zero-initialised SRAM array. It
//               carries the re-init request and status, the read port and the
//               masked write port.
// Revision    : 1.0  initial release
// ============================================================================
interface sram_array_1r1w_init_if #(
  parameter int ADDR_W   = 7,
  parameter int WIDTH    = 51,
  parameter int MASK_SEG = 1
);
  // Re-initialisation request and ready status
  logic                init_req;
  logic                init_done;

  // Read port
  logic                R0_en;
  logic [ADDR_W-1:0]   R0_addr;
  logic [WIDTH-1:0]    R0_data;
  logic                R0_valid;

  // Write port
  logic                W0_en;
  logic [ADDR_W-1:0]   W0_addr;
  logic [WIDTH-1:0]    W0_data;
  logic [MASK_SEG-1:0] W0_mask;

  // Table owner side: issues requests, observes status and read data
  modport master (
    output init_req,
    input  init_done,
    output R0_en,
    output R0_addr,
    input  R0_data,
    input  R0_valid,
    output W0_en,
    output W0_addr,
    output W0_data,
    output W0_mask
  );

  // Array side: serves requests, drives status and read data
  modport slave (
    input  init_req,
    output init_done,
    input  R0_en,
    input  R0_addr,
    output R0_data,
    output R0_valid,
    input  W0_en,
    input  W0_addr,
    input  W0_data,
    input  W0_mask
  );
endinterface
`default_nettype wire

// File: rtl/sram_array_1r1w_init.sv
`default_nettype none
// ============================================================================
// Module      : sram_array_1r1w_init
// Description : Single-clock 1-read/1-write SRAM array with per-segment write
//               mask, selectable read-during-write behaviour and a hardware
//               zero-initialisation sweep after reset or on request.
// Revision    : 1.0  initial release
// ============================================================================
module sram_array_1r1w_init #(
  parameter int DEPTH    = 128,
  parameter int WIDTH    = 51,
  parameter int MASK_SEG = 1,
  parameter int BYPASS   = 1,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  sram_array_1r1w_init_if.slave bus
);

  // Each mask bit owns one equal-width slice of the entry; WIDTH must be an
  // exact multiple of MASK_SEG.
  localparam int SEG_W = WIDTH / MASK_SEG;

  // Controller states
  localparam logic [0:0] S_INIT  = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  // Sweep counter constants; DEPTH is a power of two so the counter wraps
  // back to zero by itself after the last entry.
  localparam logic [ADDR_W-1:0] C_ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] C_ADDR_ONE  = ADDR_W'(1);

  logic [0:0]        state_q;
  logic [0:0]        state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;
  logic [WIDTH-1:0]  r0_data_q;
  logic [WIDTH-1:0]  r0_data_d;
  logic              r0_valid_q;
  logic              r0_valid_d;

  logic              ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  rd_word;

  assign ready = (state_q == S_READY);

  // The sweep owns the write port while initialising; afterwards the user
  // write address takes over.
  assign wr_addr = ready ? bus.W0_addr : cnt_q;

  assign bus.init_done = ready;
  assign bus.R0_data   = r0_data_q;
  assign bus.R0_valid  = r0_valid_q;

  // Controller next state: walk the sweep counter, or leave READY on request
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      cnt_d = cnt_q + C_ADDR_ONE;
      if (cnt_q == C_ADDR_LAST) begin
        state_d = S_READY;
      end
    end else if (bus.init_req) begin
      // Accesses in this cycle still complete; the sweep begins next edge.
      state_d = S_INIT;
      cnt_d   = '0;
    end
  end

  // Read result register: forced to zero while initialising, loaded on an
  // accepted read, otherwise held so the last result stays stable.
  always_comb begin
    r0_valid_d = ready & bus.R0_en;
    r0_data_d  = r0_data_q;
    if (!ready) begin
      r0_data_d = '0;
    end else if (bus.R0_en) begin
      r0_data_d = rd_word;
    end
  end

  // Controller and read-port state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_INIT;
      cnt_q      <= '0;
      r0_data_q  <= '0;
      r0_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      r0_data_q  <= r0_data_d;
      r0_valid_q <= r0_valid_d;
    end
  end

  // One storage slice per mask segment, so a masked write is simply a set of
  // independent per-slice write enables with no read-modify-write.
  generate
    for (genvar s = 0; s < MASK_SEG; s++) begin : g_seg
      logic [SEG_W-1:0] seg_ram [DEPTH];
      logic             seg_wr_en;
      logic [SEG_W-1:0] seg_wr_data;
      logic [SEG_W-1:0] seg_rd_data;

      // Slice write enable: every slice during the sweep, masked slices on a
      // user write, never on a reset edge.
      always_comb begin
        seg_wr_en   = 1'b0;
        seg_wr_data = '0;
        if (!reset) begin
          if (!ready) begin
            seg_wr_en   = 1'b1;
            seg_wr_data = '0;
          end else if (bus.W0_en && bus.W0_mask[s]) begin
            seg_wr_en   = 1'b1;
            seg_wr_data = bus.W0_data[s*SEG_W +: SEG_W];
          end
        end
      end

      // Storage slice write; contents are not reset, the sweep clears them
      always_ff @(posedge clock) begin
        if (seg_wr_en) begin
          seg_ram[wr_addr] <= seg_wr_data;
        end
      end

      if (BYPASS != 0) begin : g_bypass
        // Same-address write in the read cycle: forward the new slice data
        always_comb begin
          seg_rd_data = seg_ram[bus.R0_addr];
          if (bus.W0_en && bus.W0_mask[s] && (bus.W0_addr == bus.R0_addr)) begin
            seg_rd_data = bus.W0_data[s*SEG_W +: SEG_W];
          end
        end
      end else begin : g_no_bypass
        // Array read happens before the edge, so this is the pre-write entry
        always_comb begin
          seg_rd_data = seg_ram[bus.R0_addr];
        end
      end

      assign rd_word[s*SEG_W +: SEG_W] = seg_rd_data;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sram_array_1r1w_init.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_array_1r1w_init
// Description : Self-checking bench for sram_array_1r1w_init. Two arrays
//               (forwarding and old-data read-during-write) share one stimulus
//               stream and are compared each cycle against a reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sram_array_1r1w_init;

  localparam int DEPTH    = 128;
  localparam int WIDTH    = 51;
  localparam int MASK_SEG = 3;
  localparam int SEG_W    = WIDTH / MASK_SEG;
  localparam int ADDR_W   = 7;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                init_req = 1'b0;
  logic                r0_en = 1'b0;
  logic [ADDR_W-1:0]   r0_addr = '0;
  logic                w0_en = 1'b0;
  logic [ADDR_W-1:0]   w0_addr = '0;
  logic [WIDTH-1:0]    w0_data = '0;
  logic [MASK_SEG-1:0] w0_mask = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [WIDTH-1:0] mem_m [DEPTH];
  int               sweep_left = DEPTH;
  logic [WIDTH-1:0] exp_db = '0;
  logic [WIDTH-1:0] exp_dn = '0;
  logic             exp_v  = 1'b0;

  always #5 clk = ~clk;

  sram_array_1r1w_init_if #(.ADDR_W(ADDR_W), .WIDTH(WIDTH), .MASK_SEG(MASK_SEG)) if_b ();
  sram_array_1r1w_init_if #(.ADDR_W(ADDR_W), .WIDTH(WIDTH), .MASK_SEG(MASK_SEG)) if_n ();

  assign if_b.init_req = init_req;
  assign if_b.R0_en    = r0_en;
  assign if_b.R0_addr  = r0_addr;
  assign if_b.W0_en    = w0_en;
  assign if_b.W0_addr  = w0_addr;
  assign if_b.W0_data  = w0_data;
  assign if_b.W0_mask  = w0_mask;
  assign if_n.init_req = init_req;
  assign if_n.R0_en    = r0_en;
  assign if_n.R0_addr  = r0_addr;
  assign if_n.W0_en    = w0_en;
  assign if_n.W0_addr  = w0_addr;
  assign if_n.W0_data  = w0_data;
  assign if_n.W0_mask  = w0_mask;

  sram_array_1r1w_init #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_SEG(MASK_SEG), .BYPASS(1)
  ) dut_b (
    .clock (clk),
    .reset (reset),
    .bus   (if_b)
  );

  sram_array_1r1w_init #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_SEG(MASK_SEG), .BYPASS(0)
  ) dut_n (
    .clock (clk),
    .reset (reset),
    .bus   (if_n)
  );

  // Apply a segment mask: each set mask bit takes the new data for its slice
  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_w,
                                             input logic [WIDTH-1:0] new_w,
                                             input logic [MASK_SEG-1:0] m);
    logic [WIDTH-1:0] r;
    r = old_w;
    for (int b = 0; b < WIDTH; b++) begin
      if (m[b / SEG_W]) r[b] = new_w[b];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one rising edge, from the inputs present before it
  task automatic model_edge();
    logic [WIDTH-1:0] old_w;
    logic [WIDTH-1:0] new_w;
    if (reset) begin
      sweep_left = DEPTH;
      exp_db = '0;
      exp_dn = '0;
      exp_v  = 1'b0;
    end else if (sweep_left > 0) begin
      mem_m[DEPTH - sweep_left] = '0;
      sweep_left--;
      exp_db = '0;
      exp_dn = '0;
      exp_v  = 1'b0;
    end else begin
      exp_v = r0_en;
      if (r0_en) begin
        old_w = mem_m[r0_addr];
        new_w = (w0_en && (w0_addr == r0_addr)) ? merge(old_w, w0_data, w0_mask) : old_w;
        exp_db = new_w;
        exp_dn = old_w;
      end
      if (w0_en) mem_m[w0_addr] = merge(mem_m[w0_addr], w0_data, w0_mask);
      if (init_req) sweep_left = DEPTH;
    end
  endtask

  // Advance one clock, update the model and compare both arrays
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("init_done_byp", 64'(if_b.init_done), 64'(sweep_left == 0));
    check("init_done_old", 64'(if_n.init_done), 64'(sweep_left == 0));
    check("valid_byp",     64'(if_b.R0_valid),  64'(exp_v));
    check("valid_old",     64'(if_n.R0_valid),  64'(exp_v));
    check("data_byp",      64'(if_b.R0_data),   64'(exp_db));
    check("data_old",      64'(if_n.R0_data),   64'(exp_dn));
  endtask

  task automatic idle();
    r0_en = 1'b0; w0_en = 1'b0; init_req = 1'b0;
  endtask

  task automatic wr(input int a, input logic [WIDTH-1:0] d, input logic [MASK_SEG-1:0] m);
    w0_en = 1'b1; w0_addr = ADDR_W'(a); w0_data = d; w0_mask = m;
  endtask

  task automatic rd(input int a);
    r0_en = 1'b1; r0_addr = ADDR_W'(a);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

    // Reset held for three edges
    reset = 1'b1;
    repeat (3) step();
    check("reset_done",  64'(if_b.init_done), 64'(0));
    check("reset_valid", 64'(if_b.R0_valid),  64'(0));
    check("reset_data",  64'(if_n.R0_data),   64'(0));

    // Sweep after release, with accesses attempted that must be ignored
    reset = 1'b0;
    wr(0, 51'h123, 3'b111);
    rd(0);
    cnt = 0;
    while (!if_b.init_done && cnt < 300) begin
      step();
      cnt++;
      check("init_ignored_valid", 64'(if_b.R0_valid), 64'(0));
    end
    check("sweep_len", 64'(cnt), 64'(DEPTH));
    idle();

    // Every entry reads zero
    for (int a = 0; a < DEPTH; a++) begin
      rd(a);
      step();
      check("sweep_zero_data", 64'(if_b.R0_data), 64'(0));
      check("sweep_zero_valid", 64'(if_b.R0_valid), 64'(1));
    end
    idle();

    // Masked write: clear the middle segment of an all-ones entry
    wr(5, 51'h7_FFFF_FFFF_FFFF, 3'b111); step();
    wr(5, 51'h0, 3'b010); step();
    idle(); rd(5); step();
    check("mask_mid_byp", 64'(if_b.R0_data), 64'(51'h7_FFFC_0001_FFFF));
    check("mask_mid_old", 64'(if_n.R0_data), 64'(51'h7_FFFC_0001_FFFF));
    idle(); wr(5, 51'h0, 3'b000); rd(5); step();
    check("mask_none", 64'(if_b.R0_data), 64'(51'h7_FFFC_0001_FFFF));
    idle();

    // Same-address read and write in one cycle
    wr(9, 51'h1, 3'b111); step();
    idle(); wr(9, 51'h2, 3'b111); rd(9); step();
    check("rdw_byp", 64'(if_b.R0_data), 64'(2));
    check("rdw_old", 64'(if_n.R0_data), 64'(1));
    idle(); rd(9); step();
    check("rdw_after_byp", 64'(if_b.R0_data), 64'(2));
    check("rdw_after_old", 64'(if_n.R0_data), 64'(2));
    idle();

    // Hold: read data stays put while the entry is rewritten without a read
    wr(2, 51'hA, 3'b111); step();
    idle(); rd(2); step();
    check("hold_read", 64'(if_b.R0_data), 64'(51'hA));
    idle(); wr(2, 51'hB, 3'b111); step();
    check("hold_data", 64'(if_b.R0_data), 64'(51'hA));
    check("hold_valid", 64'(if_b.R0_valid), 64'(0));
    idle(); rd(2); step();
    check("hold_new", 64'(if_n.R0_data), 64'(51'hB));
    idle();

    // Randomised traffic on a small address window to force collisions
    for (int i = 0; i < 600; i++) begin
      r0_en    = 1'($urandom_range(0, 1));
      r0_addr  = ADDR_W'($urandom_range(0, 15));
      w0_en    = 1'($urandom_range(0, 1));
      w0_addr  = ADDR_W'($urandom_range(0, 15));
      w0_data  = WIDTH'({$urandom(), $urandom()});
      w0_mask  = MASK_SEG'($urandom_range(0, 7));
      init_req = ($urandom_range(0, 299) == 0);
      step();
    end
    idle();
    cnt = 0;
    while (!if_b.init_done && cnt < 300) begin step(); cnt++; end
    check("random_settle", 64'(if_b.init_done), 64'(1));

    // Re-init request, then a reset part-way through the sweep
    for (int a = 0; a < 4; a++) begin
      wr(a, WIDTH'((a + 1) * 32'h111), 3'b111); step();
    end
    idle(); init_req = 1'b1; step();
    init_req = 1'b0;
    check("reinit_fall", 64'(if_b.init_done), 64'(0));
    repeat (39) step();
    check("reinit_mid", 64'(if_n.init_done), 64'(0));
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    cnt = 0;
    while (!if_b.init_done && cnt < 300) begin step(); cnt++; end
    check("resweep_len", 64'(cnt), 64'(DEPTH));
    for (int a = 0; a < 4; a++) begin
      rd(a); step();
      check("reinit_zero", 64'(if_b.R0_data), 64'(0));
      check("reinit_valid", 64'(if_n.R0_valid), 64'(1));
    end
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
